hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and halt controller for the 16-bit, 5-stage core. It sits directly downstream of the decode control unit. It consumes that unit's 7-bit control vector and 2-bit register-read enables for the instruction in ID, together with the register specifiers. It tracks in-flight writers in EX and MEM with an internal scoreboard and drives PC/IF-ID stall, IF-ID flush and ID-EX bubble. It also sequences the HLT drain down to a sticky halted state.

## Interface
- No parameters. Widths are fixed by the ISA: 4-bit register specifiers and 7-bit control vector.
- clk  in  1  core clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- id_ctrl  in  7  decode control vector: bit0 Halt, 1 RegWrite, 2 MemToReg, 3 MemWrite, 4 MemRead, 5 Branch, 6 ALUSrc.
- id_re  in  2  read enables. Bit0 gates the id_rs compare; bit1 gates the id_rt compare.
- id_rs, id_rt  in  4  source registers of the instruction in ID.
- id_wreg  in  4  destination register of the instruction in ID. Decode supplies 4'hF for JAL.
- ex_br_taken  in  1  the branch or JR in EX resolved taken this cycle.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold the IF-ID register.
- ifid_flush  out  1  zero the IF-ID register.
- idex_bubble  out  1  load a NOP into ID-EX.
- draining  out  1  the HLT drain is in progress.
- halted  out  1  sticky halt. Registered.

## Operation
- **Scoreboard.** Two slots, EX and MEM. Each slot holds {valid, regwrite, memread, wreg}.
  - Every cycle: MEM <= EX.
  - EX <= the ID entry, unless idex_bubble is asserted, in which case EX <= 0.
- **Register 0.** It never causes a hazard, either as a source or as a writer.
- **Source match.** A source s matches a slot when the slot has valid & regwrite & wreg==s & s!=0, and s's read enable is set.
- **Load-use stall, FWD_EN defined.** stall = a source matches the EX slot and that slot has memread.
- **RAW stall, FWD_EN undefined.** stall = a source matches the EX slot or the MEM slot. The register file writes before it reads, so WB never conflicts.
- **Stall outputs.** pc_stall = ifid_stall = idex_bubble = stall.
- **Flush.** ex_br_taken gives ifid_flush=1 and idex_bubble=1, with pc_stall=0 and ifid_stall=0. Flush has priority over stall, and over HLT in ID.
- **FSM states.** RUN, DRAIN, HALT.
  - RUN -> DRAIN when id_ctrl[0] is set, stall=0 and ex_br_taken=0. The drain counter loads 3.
  - DRAIN: pc_stall=1, ifid_stall=1, idex_bubble=1 and draining=1. The counter decrements each cycle. At 0, go to HALT.
  - HALT: halted=1, pc_stall=1, ifid_stall=1, idex_bubble=1. The FSM leaves HALT only on rst.
- **Reset.** Every output is 0. Scoreboard slots are invalid. State is RUN. Counter is 0. Reset takes effect mid-stall or mid-drain with no residue.

## Timing
- pc_stall, ifid_stall, ifid_flush and idex_bubble are combinational from the current ID inputs, ex_br_taken, the registered scoreboard and the registered state. They are valid in the same cycle.
- halted and draining come from registered state.
- Load-use with FWD_EN: exactly 1 stall cycle.
- Without FWD_EN: a dependent immediately after its writer stalls 2 cycles. With one independent instruction between them, it stalls 1 cycle.
- HLT decoded in cycle t: draining is 1 in cycles t+1..t+3 and halted is 1 from cycle t+4. Three older instructions retire during the drain.
- HLT and ex_br_taken in the same cycle: the HLT is flushed and the FSM stays in RUN.

## Configuration
- HAZARD_FWD_EN defined: the core has EX/MEM->EX forwarding. Only load-use stalls, and only against the EX slot.
- HAZARD_FWD_EN undefined: no forwarding. Any RAW against the EX or MEM slot stalls. The memread bit is unused.

## Structure
- Package hazard_pkg holds:
  - the control-bit index constants (HALT_B=0 .. ALUSRC_B=6) and RE0_B/RE1_B;
  - the FSM state enum {RUN, DRAIN, HALT};
  - DRAIN_CYCLES=3;
  - LINK_REG=4'hF;
  - the scoreboard entry struct.
- One sub-module, hazard_scoreboard. It is the 2-slot shift register with a bubble input, and it exposes its match outputs.

## Test plan
- LW R3 then ADD R4,R3,R5 (re=2'b11). With HAZARD_FWD_EN: 1 cycle of pc_stall, ifid_stall and idex_bubble. Without it: 2 cycles.
- LW R0 then ADD R4,R0,R5 -> no stall under either config.
- Stall in progress while ex_br_taken=1 -> in that cycle ifid_flush=1, idex_bubble=1 and pc_stall=0. In the next cycle the EX slot is invalid.
- HLT in ID (id_ctrl=7'b0000001) -> draining=1 for 3 cycles, then halted=1 holds for 20 cycles with pc_stall=1.
- HLT in ID with ex_br_taken=1 in the same cycle -> draining stays 0 and the FSM stays in RUN.
- rst asserted during DRAIN and during a stall -> next cycle all outputs are 0, the state is RUN, and a following independent ADD does not stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard and halt controller of the 16-bit 5-stage core:
// decode control-vector bit positions, read-enable bit positions, FSM state encoding,
// drain length and the scoreboard entry layout.
package hazard_pkg;

    // Decode control vector bit positions
    localparam int HALT_B     = 0;
    localparam int REGWR_B    = 1;
    localparam int MEMTOREG_B = 2;
    localparam int MEMWR_B    = 3;
    localparam int MEMRD_B    = 4;
    localparam int BRANCH_B   = 5;
    localparam int ALUSRC_B   = 6;

    // Register read-enable bit positions
    localparam int RE0_B = 0;   // gates the rs compare
    localparam int RE1_B = 1;   // gates the rt compare

    // Number of cycles the pipeline is allowed to retire older work after HLT
    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    // Destination register decode supplies for JAL
    localparam logic [3:0] LINK_REG = 4'hF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memread;
        logic [3:0] wreg;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, regwrite: 1'b0, memread: 1'b0, wreg: 4'h0};

    // A source hits a slot only when it is actually read, is not R0, and the slot
    // holds a live writer of that register.
    function automatic logic src_hit(input sb_entry_t slot, input logic [3:0] src, input logic en);
        return en & slot.valid & slot.regwrite & (slot.wreg == src) & (src != 4'h0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot in-flight writer scoreboard (EX, MEM). The EX slot takes the ID entry or
// an empty entry when a bubble is inserted; MEM always takes the old EX slot.
// Exposes the per-slot source match results and the EX load-use match.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  sb_entry_t  id_entry_i,
    input  logic       bubble_i,
    input  logic [3:0] rs_i,
    input  logic [3:0] rt_i,
    input  logic [1:0] re_i,
    output logic       match_ex_o,
    output logic       match_mem_o,
    output logic       load_use_o
);

    sb_entry_t ex_q;
    sb_entry_t ex_d;
    sb_entry_t mem_q;
    sb_entry_t mem_d;
    logic      unused_s;

    // Slot advance: a bubble empties the EX slot, MEM follows EX unconditionally
    always_comb begin
        ex_d  = SB_EMPTY;
        mem_d = ex_q;
        if (bubble_i) begin
            ex_d = SB_EMPTY;
        end else begin
            ex_d = id_entry_i;
        end
    end

    // Slot registers, cleared to invalid on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= SB_EMPTY;
            mem_q <= SB_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign match_ex_o  = src_hit(ex_q, rs_i, re_i[RE0_B]) | src_hit(ex_q, rt_i, re_i[RE1_B]);
    assign match_mem_o = src_hit(mem_q, rs_i, re_i[RE0_B]) | src_hit(mem_q, rt_i, re_i[RE1_B]);
    assign load_use_o  = match_ex_o & ex_q.memread;

    // A load already in MEM has its data ready by the time a consumer needs it
    assign unused_s = mem_q.memread;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and halt controller. Produces PC/IF-ID stall, IF-ID flush and
// ID-EX bubble from the ID instruction, the EX/MEM scoreboard and branch resolution,
// and sequences HLT through a fixed drain into a sticky halted state.
// Build option HAZARD_FWD_EN: core forwards EX/MEM->EX, so only load-use against
// the EX slot stalls; otherwise any RAW against EX or MEM stalls.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] id_ctrl,
    input  logic [1:0] id_re,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic [3:0] id_wreg,
    input  logic       ex_br_taken,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       draining,
    output logic       halted
);

    hz_state_e  state_q;
    hz_state_e  state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       halted_q;
    logic       draining_q;

    sb_entry_t  id_entry_s;
    logic       match_ex_s;
    logic       match_mem_s;
    logic       load_use_s;
    logic       stall_s;
    logic       pc_stall_s;
    logic       ifid_stall_s;
    logic       ifid_flush_s;
    logic       idex_bubble_s;
    logic       unused_s;

    assign id_entry_s = '{valid: 1'b1, regwrite: id_ctrl[REGWR_B],
                          memread: id_ctrl[MEMRD_B], wreg: id_wreg};

    hazard_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .id_entry_i  (id_entry_s),
        .bubble_i    (idex_bubble_s),
        .rs_i        (id_rs),
        .rt_i        (id_rt),
        .re_i        (id_re),
        .match_ex_o  (match_ex_s),
        .match_mem_o (match_mem_s),
        .load_use_o  (load_use_s)
    );

`ifdef HAZARD_FWD_EN
    assign stall_s  = load_use_s;
    assign unused_s = ^{id_ctrl[MEMTOREG_B], id_ctrl[MEMWR_B], id_ctrl[BRANCH_B],
                        id_ctrl[ALUSRC_B], match_ex_s, match_mem_s};
`else
    assign stall_s  = match_ex_s | match_mem_s;
    assign unused_s = ^{id_ctrl[MEMTOREG_B], id_ctrl[MEMWR_B], id_ctrl[BRANCH_B],
                        id_ctrl[ALUSRC_B], load_use_s};
`endif

    // State register, drain counter and registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= 2'd0;
            halted_q   <= 1'b0;
            draining_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            halted_q   <= (state_d == HALT);
            draining_q <= (state_d == DRAIN);
        end
    end

    // Next state: HLT only commits when it is neither stalled nor flushed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (id_ctrl[HALT_B] && !stall_s && !ex_br_taken) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_CYCLES;
                end else begin
                    state_d = RUN;
                    cnt_d   = cnt_q;
                end
            end
            DRAIN: begin
                if (cnt_q <= 2'd1) begin
                    state_d = HALT;
                    cnt_d   = 2'd0;
                end else begin
                    state_d = DRAIN;
                    cnt_d   = cnt_q - 2'd1;
                end
            end
            HALT: begin
                state_d = HALT;
                cnt_d   = 2'd0;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Pipeline control: flush beats stall in RUN; DRAIN and HALT freeze the front end
    always_comb begin
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        if (rst) begin
            pc_stall_s    = 1'b0;
            ifid_stall_s  = 1'b0;
            ifid_flush_s  = 1'b0;
            idex_bubble_s = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_br_taken) begin
                        ifid_flush_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else if (stall_s) begin
                        pc_stall_s    = 1'b1;
                        ifid_stall_s  = 1'b1;
                        idex_bubble_s = 1'b1;
                    end else begin
                        idex_bubble_s = 1'b0;
                    end
                end
                DRAIN, HALT: begin
                    pc_stall_s    = 1'b1;
                    ifid_stall_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end
                default: begin
                    idex_bubble_s = 1'b0;
                end
            endcase
        end
    end

    assign pc_stall    = pc_stall_s;
    assign ifid_stall  = ifid_stall_s;
    assign ifid_flush  = ifid_flush_s;
    assign idex_bubble = idex_bubble_s;
    assign draining    = draining_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Outputs are compared as the 6-bit vector
// {pc_stall, ifid_stall, ifid_flush, idex_bubble, draining, halted}.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] id_ctrl;
    logic [1:0] id_re;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic [3:0] id_wreg;
    logic       ex_br_taken;
    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       draining;
    logic       halted;

    int n_vec;
    int n_err;

    localparam logic [6:0] C_NOP = 7'b0000000;
    localparam logic [6:0] C_HLT = 7'b0000001;
    localparam logic [6:0] C_ADD = 7'b0000010;
    localparam logic [6:0] C_LW  = 7'b1010110;

    localparam logic [5:0] V_Z = 6'b000000;   // idle
    localparam logic [5:0] V_S = 6'b110100;   // stall
    localparam logic [5:0] V_F = 6'b001100;   // flush
    localparam logic [5:0] V_D = 6'b110110;   // draining
    localparam logic [5:0] V_H = 6'b110101;   // halted

`ifdef HAZARD_FWD_EN
    localparam int LU_STALLS   = 1;
    localparam int ALU0_STALLS = 0;
    localparam int ALU1_STALLS = 0;
`else
    localparam int LU_STALLS   = 2;
    localparam int ALU0_STALLS = 2;
    localparam int ALU1_STALLS = 1;
`endif

    hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .id_ctrl     (id_ctrl),
        .id_re       (id_re),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_wreg     (id_wreg),
        .ex_br_taken (ex_br_taken),
        .pc_stall    (pc_stall),
        .ifid_stall  (ifid_stall),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .draining    (draining),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic set_id(input logic [6:0] c, input logic [1:0] re, input logic [3:0] rs,
                          input logic [3:0] rt, input logic [3:0] wr, input logic br);
        id_ctrl     = c;
        id_re       = re;
        id_rs       = rs;
        id_rt       = rt;
        id_wreg     = wr;
        ex_br_taken = br;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Check the current cycle's outputs, then advance one clock
    task automatic cyc(input string tag, input logic [5:0] exp);
        #1;
        check_vec(tag, {pc_stall, ifid_stall, ifid_flush, idex_bubble, draining, halted}, exp);
        tick();
    endtask

    task automatic nops(input int n);
        set_id(C_NOP, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Writer of R3, gap independent ops, then ADD R4,R3,R5 held until it issues
    task automatic dep_test(input string tag, input logic [6:0] wctrl, input int gap, input int nst);
        set_id(wctrl, 2'b01, 4'd1, 4'd0, 4'd3, 1'b0);
        cyc({tag, "_writer"}, V_Z);
        for (int g = 0; g < gap; g++) begin
            set_id(C_ADD, 2'b11, 4'd1, 4'd2, 4'd6, 1'b0);
            cyc({tag, "_gap"}, V_Z);
        end
        for (int i = 0; i <= nst; i++) begin
            set_id(C_ADD, 2'b11, 4'd3, 4'd5, 4'd4, 1'b0);
            cyc($sformatf("%s_c%0d", tag, i), (i < nst) ? V_S : V_Z);
        end
        nops(3);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        set_id(C_NOP, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        cyc("reset", V_Z);

        dep_test("loaduse", C_LW, 0, LU_STALLS);
        dep_test("alu_adj", C_ADD, 0, ALU0_STALLS);
        dep_test("alu_gap1", C_ADD, 1, ALU1_STALLS);

        // Loads to R0 never create a hazard
        set_id(C_LW, 2'b01, 4'd1, 4'd0, 4'd0, 1'b0);
        cyc("r0_writer", V_Z);
        set_id(C_ADD, 2'b11, 4'd0, 4'd5, 4'd4, 1'b0);
        cyc("r0_c0", V_Z);
        cyc("r0_c1", V_Z);
        nops(3);

        // rt matches but its read enable is off
        set_id(C_LW, 2'b01, 4'd1, 4'd0, 4'd3, 1'b0);
        cyc("re_writer", V_Z);
        set_id(C_ADD, 2'b01, 4'd5, 4'd3, 4'd4, 1'b0);
        cyc("re_gated", V_Z);
        nops(3);

        // Taken branch during a load-use stall: flush wins, EX gets a bubble
        set_id(C_LW, 2'b01, 4'd1, 4'd0, 4'd3, 1'b0);
        cyc("fl_writer", V_Z);
        set_id(C_ADD, 2'b11, 4'd3, 4'd5, 4'd4, 1'b1);
        cyc("fl_flush", V_F);
        set_id(C_ADD, 2'b01, 4'd4, 4'd0, 4'd7, 1'b0);
        cyc("fl_ex_empty", V_Z);
        nops(3);

        // HLT flushed in the same cycle never starts the drain
        set_id(C_HLT, 2'b00, 4'd0, 4'd0, 4'd0, 1'b1);
        cyc("hltbr_flush", V_F);
        set_id(C_NOP, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc("hltbr_run0", V_Z);
        cyc("hltbr_run1", V_Z);

        // Reset in the middle of a stall leaves no scoreboard residue
        set_id(C_LW, 2'b01, 4'd1, 4'd0, 4'd3, 1'b0);
        cyc("rs_writer", V_Z);
        set_id(C_ADD, 2'b11, 4'd3, 4'd5, 4'd4, 1'b0);
        cyc("rs_stall", V_S);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc("rs_after", V_Z);
        set_id(C_ADD, 2'b11, 4'd1, 4'd2, 4'd8, 1'b0);
        cyc("rs_indep", V_Z);
        nops(3);

        // Reset in the middle of the drain returns to RUN
        set_id(C_HLT, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc("rd_hlt", V_Z);
        set_id(C_NOP, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc("rd_drain", V_D);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc("rd_after0", V_Z);
        set_id(C_ADD, 2'b11, 4'd1, 4'd2, 4'd8, 1'b0);
        cyc("rd_indep", V_Z);
        nops(3);

        // Full halt sequence: three drain cycles, then sticky halt
        set_id(C_HLT, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        cyc("hlt_t0", V_Z);
        set_id(C_NOP, 2'b00, 4'd0, 4'd0, 4'd0, 1'b0);
        for (int i = 1; i <= 3; i++) cyc($sformatf("hlt_drain%0d", i), V_D);
        for (int i = 0; i < 20; i++) cyc($sformatf("hlt_halt%0d", i), V_H);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc("hlt_reset", V_Z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
